// File: rtl/periph_bus_arbiter.sv
// Round-robin two-master, one-slave arbiter for the valid/ready peripheral bus.
// One transaction in flight at a time. A watchdog ends slave accesses that stall.
module periph_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 31,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  // master 0
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_write,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  // master 1
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_write,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  // slave
  output logic                  s_valid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_write,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [31:0]           s_rdata,
  input  logic                  s_ready,
  // status
  output logic                  busy,
  output logic                  timeout_pulse,
  output logic                  err_sticky,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StTerm} state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  term_master_q, term_master_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  // Currently selected master's request fields.
  logic                  sel;
  logic                  cur_valid;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_write;
  logic [31:0]           cur_wdata;
  logic [3:0]            cur_wstrb;

  always_comb begin
    sel       = (state_q == StGrant1);
    cur_valid = sel ? m1_valid : m0_valid;
    cur_addr  = sel ? m1_addr  : m0_addr;
    cur_write = sel ? m1_write : m0_write;
    cur_wdata = sel ? m1_wdata : m0_wdata;
    cur_wstrb = sel ? m1_wstrb : m0_wstrb;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    tmo_cnt_d     = tmo_cnt_q;
    term_master_d = term_master_q;
    err_sticky_d  = err_sticky_q;
    err_addr_d    = err_addr_q;

    s_valid       = 1'b0;
    s_addr        = '0;
    s_write       = 1'b0;
    s_wdata       = '0;
    s_wstrb       = '0;
    m0_ready      = 1'b0;
    m1_ready      = 1'b0;
    m0_rdata      = '0;
    m1_rdata      = '0;
    timeout_pulse = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m0_valid && m1_valid) begin
          // Tie goes to whoever was not served last.
          if (last_grant_q) begin
            state_d      = StGrant0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = StGrant1;
            last_grant_d = 1'b1;
          end
        end else if (m0_valid) begin
          state_d      = StGrant0;
          last_grant_d = 1'b0;
        end else if (m1_valid) begin
          state_d      = StGrant1;
          last_grant_d = 1'b1;
        end
      end

      StGrant0, StGrant1: begin
        s_valid = cur_valid;
        s_addr  = cur_addr;
        s_write = cur_write;
        s_wdata = cur_wdata;
        s_wstrb = cur_wstrb;
        if (sel) begin
          m1_ready = s_ready & cur_valid;
          m1_rdata = s_rdata;
        end else begin
          m0_ready = s_ready & cur_valid;
          m0_rdata = s_rdata;
        end

        if (!cur_valid) begin
          // Master withdrew its request: abandon without completing.
          state_d   = StIdle;
          tmo_cnt_d = '0;
        end else if (s_ready) begin
          state_d   = StIdle;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d       = StTerm;
          term_master_d = sel;
          err_addr_d    = cur_addr;
          err_sticky_d  = 1'b1;
          tmo_cnt_d     = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      StTerm: begin
        timeout_pulse = 1'b1;
        if (term_master_q) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
        tmo_cnt_d = '0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      tmo_cnt_q     <= '0;
      term_master_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      tmo_cnt_q     <= tmo_cnt_d;
      term_master_q <= term_master_d;
      err_sticky_q  <= err_sticky_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: directed transactions push expected
// completions; a monitor pops and compares whenever a master sees ready.
module tb_periph_bus_arbiter;

  localparam int unsigned AW  = 31;
  localparam int unsigned TMO = 8;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          m0_valid = 1'b0, m1_valid = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic          m0_write = 1'b0, m1_write = 1'b0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready;
  logic          s_valid, s_write;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic [31:0]   s_rdata = '0;
  logic          s_ready = 1'b0;
  logic          busy, timeout_pulse, err_sticky;
  logic [AW-1:0] err_addr;

  periph_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .m0_valid     (m0_valid),
    .m0_addr      (m0_addr),
    .m0_write     (m0_write),
    .m0_wdata     (m0_wdata),
    .m0_wstrb     (m0_wstrb),
    .m0_rdata     (m0_rdata),
    .m0_ready     (m0_ready),
    .m1_valid     (m1_valid),
    .m1_addr      (m1_addr),
    .m1_write     (m1_write),
    .m1_wdata     (m1_wdata),
    .m1_wstrb     (m1_wstrb),
    .m1_rdata     (m1_rdata),
    .m1_ready     (m1_ready),
    .s_valid      (s_valid),
    .s_addr       (s_addr),
    .s_write      (s_write),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_rdata      (s_rdata),
    .s_ready      (s_ready),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .err_sticky   (err_sticky),
    .err_addr     (err_addr)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Slave model controls: ready arrives slave_lat cycles after s_valid rises
  // (negative = never). Reads return a fixed value or an address-derived one.
  int          slave_lat = -1;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rd  = '0;
  int          vcnt      = 0;

  bit          exp_m[$];
  logic [31:0] exp_rd[$];
  bit          busy_chk = 1'b0;
  bit          mon_m, mon_em;
  logic [31:0] mon_rd, mon_er;
  int          k, n;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [AW-1:0] a);
    return {1'b0, a} ^ 32'hC0DE_0000;
  endfunction

  task automatic push_exp(input bit m, input logic [31:0] rd);
    exp_m.push_back(m);
    exp_rd.push_back(rd);
  endtask

  // Issue one transaction from master m and hold it until its ready is seen.
  task automatic drive(input bit m, input logic [AW-1:0] a, input bit wr,
                       input logic [31:0] wd, input logic [3:0] ws);
    bit got = 1'b0;
    if (!m) begin
      m0_valid = 1'b1; m0_addr = a; m0_write = wr; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_write = wr; m1_wdata = wd; m1_wstrb = ws;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge sys_clk);
      if ((!m && m0_ready) || (m && m1_ready)) got = 1'b1;
    end
    if (!got) check(1'b0, m ? "m1_ready_wait" : "m0_ready_wait", 32'd0, 32'd1);
    @(posedge sys_clk);
    #1;
    if (!m) begin
      m0_valid = 1'b0; m0_addr = '0; m0_write = 1'b0; m0_wdata = '0; m0_wstrb = '0;
    end else begin
      m1_valid = 1'b0; m1_addr = '0; m1_write = 1'b0; m1_wdata = '0; m1_wstrb = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  // Slave model
  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      if (s_valid === 1'b1) begin
        if (slave_lat >= 0 && vcnt == slave_lat) begin
          s_ready = 1'b1;
          s_rdata = s_write ? 32'd0 : (use_fixed ? fixed_rd : slave_data(s_addr));
        end else begin
          s_ready = 1'b0;
          s_rdata = '0;
        end
        vcnt++;
      end else begin
        s_ready = 1'b0;
        s_rdata = '0;
        vcnt    = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge sys_clk);
      if (busy_chk) begin
        busy_chk = 1'b0;
        check(busy == 1'b0, "idle_gap_after_ready", 32'(busy), 32'd0);
      end
      if (m0_ready || m1_ready) begin
        check(!(m0_ready && m1_ready), "one_ready_at_a_time",
              {30'd0, m1_ready, m0_ready}, 32'd1);
        mon_m  = m1_ready;
        mon_rd = m1_ready ? m1_rdata : m0_rdata;
        if (exp_m.size() == 0) begin
          check(1'b0, "unexpected_ready", 32'(mon_m), 32'hFFFF_FFFF);
        end else begin
          mon_em = exp_m.pop_front();
          mon_er = exp_rd.pop_front();
          check(mon_m == mon_em, "grant_order", 32'(mon_m), 32'(mon_em));
          check(mon_rd == mon_er, "rdata", mon_rd, mon_er);
        end
        busy_chk = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check(s_valid == 1'b0, "rst_s_valid", 32'(s_valid), 32'd0);
    check(s_addr == '0, "rst_s_addr", 32'(s_addr), 32'd0);
    check(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
    check(!m0_ready && !m1_ready, "rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    check(timeout_pulse == 1'b0, "rst_pulse", 32'(timeout_pulse), 32'd0);
    check(err_sticky == 1'b0, "rst_err_sticky", 32'(err_sticky), 32'd0);
    check(err_addr == '0, "rst_err_addr", 32'(err_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Single read, slave latency 2
    slave_lat = 2; use_fixed = 1'b1; fixed_rd = 32'h0000_0005;
    push_exp(1'b0, 32'h0000_0005);
    fork
      drive(1'b0, 31'h10, 1'b0, 32'd0, 4'd0);
      begin
        @(negedge sys_clk);
        check(s_valid == 1'b0, "latency_idle_cycle", 32'(s_valid), 32'd0);
        @(negedge sys_clk);
        check(s_valid == 1'b1, "latency_grant_cycle", 32'(s_valid), 32'd1);
        check(s_addr == 31'h10, "read_addr_fwd", 32'(s_addr), 32'h10);
      end
    join
    use_fixed = 1'b0;

    // Contention: four rounds of constant dual requests
    do_reset();
    slave_lat = 1;
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b0, slave_data(31'(32'h20 + 4 * i)));
      push_exp(1'b1, slave_data(31'(32'h40 + 4 * i)));
    end
    fork
      for (int i = 0; i < 4; i++) drive(1'b0, 31'(32'h20 + 4 * i), 1'b0, 32'd0, 4'd0);
      for (int j = 0; j < 4; j++) drive(1'b1, 31'(32'h40 + 4 * j), 1'b0, 32'd0, 4'd0);
    join

    // Write forwarding from master 1
    slave_lat = 2;
    push_exp(1'b1, 32'd0);
    fork
      drive(1'b1, 31'h4, 1'b1, 32'hA5A5_0F0F, 4'b0011);
      begin
        k = 0;
        while (s_valid !== 1'b1 && k < 20) begin @(negedge sys_clk); k++; end
        check(s_valid == 1'b1, "wr_start", 32'(s_valid), 32'd1);
        n = 0;
        while (s_valid === 1'b1 && n < 10) begin
          check(s_addr == 31'h4, "wr_addr", 32'(s_addr), 32'h4);
          check(s_write == 1'b1, "wr_flag", 32'(s_write), 32'd1);
          check(s_wdata == 32'hA5A5_0F0F, "wr_wdata", s_wdata, 32'hA5A5_0F0F);
          check(s_wstrb == 4'b0011, "wr_wstrb", 32'(s_wstrb), 32'h3);
          check(m0_ready == 1'b0, "wr_m0_ready_quiet", 32'(m0_ready), 32'd0);
          n++;
          @(negedge sys_clk);
        end
        check(n == 3, "wr_grant_cycles", 32'(n), 32'd3);
      end
    join

    // Timeout on a master 0 read
    slave_lat = -1;
    push_exp(1'b0, 32'hDEAD_BEEF);
    fork
      drive(1'b0, 31'h100, 1'b0, 32'd0, 4'd0);
      begin
        k = 0;
        while (s_valid !== 1'b1 && k < 20) begin @(negedge sys_clk); k++; end
        n = 0;
        while (s_valid === 1'b1 && n < 20) begin n++; @(negedge sys_clk); end
        check(n == TMO, "tmo_grant_cycles", 32'(n), 32'(TMO));
        check(s_valid == 1'b0, "term_s_valid", 32'(s_valid), 32'd0);
        check(timeout_pulse == 1'b1, "term_pulse", 32'(timeout_pulse), 32'd1);
        check(busy == 1'b1, "term_busy", 32'(busy), 32'd1);
        @(negedge sys_clk);
        check(timeout_pulse == 1'b0, "pulse_one_cycle", 32'(timeout_pulse), 32'd0);
        check(err_sticky == 1'b1, "err_sticky_set", 32'(err_sticky), 32'd1);
        check(err_addr == 31'h100, "err_addr", 32'(err_addr), 32'h100);
      end
    join
    slave_lat = 1;
    push_exp(1'b1, slave_data(31'h8));
    drive(1'b1, 31'h8, 1'b0, 32'd0, 4'd0);
    check(err_sticky == 1'b1, "err_sticky_holds", 32'(err_sticky), 32'd1);

    // Reset while master 1 is stalled in its grant
    slave_lat = -1;
    m1_valid = 1'b1; m1_addr = 31'h30;
    repeat (3) @(negedge sys_clk);
    check(s_valid == 1'b1, "stall_s_valid", 32'(s_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check(s_valid == 1'b0, "async_rst_s_valid", 32'(s_valid), 32'd0);
    check(m1_ready == 1'b0, "async_rst_m1_ready", 32'(m1_ready), 32'd0);
    check(busy == 1'b0, "async_rst_busy", 32'(busy), 32'd0);
    check(err_sticky == 1'b0, "async_rst_err", 32'(err_sticky), 32'd0);
    m1_valid = 1'b0; m1_addr = '0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    slave_lat = 1;
    push_exp(1'b0, slave_data(31'h50));
    push_exp(1'b1, slave_data(31'h60));
    fork
      drive(1'b0, 31'h50, 1'b0, 32'd0, 4'd0);
      drive(1'b1, 31'h60, 1'b0, 32'd0, 4'd0);
    join

    // Master 0 abandons its request mid-grant
    slave_lat = -1;
    m0_valid = 1'b1; m0_addr = 31'h70;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check(s_valid == 1'b1, "abandon_granted", 32'(s_valid), 32'd1);
    @(negedge sys_clk);
    #2;
    m0_valid = 1'b0;
    #1;
    check(s_valid == 1'b0, "abandon_s_valid_drop", 32'(s_valid), 32'd0);
    check(busy == 1'b1, "abandon_same_cycle_busy", 32'(busy), 32'd1);
    @(negedge sys_clk);
    check(busy == 1'b0, "abandon_idle", 32'(busy), 32'd0);
    check(m0_ready == 1'b0, "abandon_no_ready", 32'(m0_ready), 32'd0);
    check(err_sticky == 1'b0, "abandon_err_sticky", 32'(err_sticky), 32'd0);
    m0_addr = '0;

    k = 0;
    while (exp_m.size() != 0 && k < 50) begin @(negedge sys_clk); k++; end
    check(exp_m.size() == 0, "scoreboard_drained", 32'(exp_m.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
